imem_bootloader: RTL and testbench
==================================

IMEM_BOOTLOADER -- requirements
Module: imem_bootloader

Interface
REQ-001 Parameter MAGIC, 8'hA5, required first byte of an image.
REQ-002 Parameter TIMEOUT, 1_000_000, maximum idle cycles between accepted bytes while loading.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  single-cycle request to begin a load.
REQ-007 rx_data  in  8  byte from the serial receiver.
REQ-008 rx_valid  in  1  rx_data is valid.
REQ-009 rx_ready  out  1  block accepts rx_data this cycle.
REQ-010 wr_strobe  out  4  per-bank imem byte write enables, bank n = wrdata[8n+7:8n].
REQ-011 wrdata  out  32  imem write word.
REQ-012 wraddr  out  14  imem word address.
REQ-013 bl_stall  out  1  holds the fetch stage and steers imem addressing to wraddr.
REQ-014 done  out  1  last load succeeded.
REQ-015 error  out  1  last load failed.

Function
REQ-016 A byte transfers only on a cycle with rx_valid=1 and rx_ready=1.
REQ-017 Image format: MAGIC, LEN_LO, LEN_HI, 4*LEN data bytes (little-endian per word), CHK.
REQ-018 LEN = {LEN_HI[5:0], LEN_LO}, range 0..16383 words; LEN_HI[7:6]!=0 -> ERROR.
REQ-019 CHK = XOR of LEN_LO, LEN_HI and all data bytes; mismatch -> ERROR.
REQ-020 States: IDLE, MAGIC, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR.
REQ-021 IDLE/DONE/ERROR + start -> MAGIC; clears done, error, word index, checksum and timeout counter.
REQ-022 MAGIC: byte==MAGIC -> LEN_LO, else -> ERROR.
REQ-023 LEN_HI: LEN==0 -> CHECK, else -> DATA.
REQ-024 DATA: 4th byte of a word -> WRITE; the 1st byte lands in wrdata[7:0].
REQ-025 WRITE: one cycle with wr_strobe=4'hF, wrdata=assembled word, wraddr=word index, rx_ready=0.
REQ-026 WRITE -> DATA with word index +1, or -> CHECK after word LEN-1.
REQ-027 CHECK: accept CHK, then -> DONE (done=1) or ERROR (error=1).
REQ-028 rx_ready=1 only in MAGIC, LEN_LO, LEN_HI, DATA and CHECK.
REQ-029 bl_stall=1 in every state except IDLE and DONE; ERROR keeps the CPU stalled until the next successful load.
REQ-030 wr_strobe=0 in every state except WRITE.
REQ-031 wraddr is the current word index in all states.
REQ-032 Timeout: in a receiving state, TIMEOUT consecutive cycles with no accepted byte -> ERROR.
REQ-033 The timeout counter restarts on every accepted byte and is held clear in WRITE.
REQ-034 start is ignored in MAGIC..CHECK.
REQ-035 Latency: the imem write occurs the cycle after the 4th byte of each word is accepted.
REQ-036 rx_data is ignored when rx_ready=0.

Reset
REQ-037 rst asserted at any time, including mid-load, forces IDLE within the same cycle.
REQ-038 Reset values: rx_ready=0, wr_strobe=0, wrdata=0, wraddr=0, bl_stall=0, done=0, error=0; counters and checksum = 0.
REQ-039 A partially written image is not rolled back by reset.

Structure
REQ-040 Package bootloader_pkg holds the state enum, the default MAGIC value and the 14-bit word-address width constant.
REQ-041 The timeout counter is a sub-module bl_timeout, with inputs clear/enable and output expired.
REQ-042 Every output is driven from a register.

Verification
REQ-043 Happy path: start; A5,02,00, bytes 78 56 34 12 EF BE AD DE, CHK=0x02^0x00^all data -> writes 0x12345678@0 and 0xDEADBEEF@1; done=1, bl_stall=0.
REQ-044 Bad magic: start; 5A -> error=1, bl_stall=1, wr_strobe never asserted.
REQ-045 Checksum fault: happy-path image with CHK xor 0x01 -> both words written, then error=1.
REQ-046 Zero length: A5,00,00,00 -> no writes, done=1; LEN_HI=0x40 -> error=1.
REQ-047 Backpressure and timeout: with TIMEOUT=16, rx_valid toggling every other cycle still loads correctly; stopping after 3 data bytes -> error exactly 16 cycles after the last accepted byte.
REQ-048 Reset mid-DATA, then a new start and a full image -> clean load with done=1; start pulsed mid-load is ignored.

Source files
------------

// File: rtl/imem_bootloader_pkg.sv
// Shared types and constants for the serial instruction-memory bootloader.
package bootloader_pkg;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
    localparam int         ADDR_W        = 14;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_MAGIC,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    function automatic logic is_rx_state(input state_t s);
        return (s == ST_MAGIC) || (s == ST_LEN_LO) || (s == ST_LEN_HI) ||
               (s == ST_DATA)  || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/imem_bootloader_if.sv
// Byte-stream input, imem write port and status of the bootloader.
interface imem_bootloader_if;

    logic                                start;
    logic [7:0]                          rx_data;
    logic                                rx_valid;
    logic                                rx_ready;
    logic [3:0]                          wr_strobe;
    logic [31:0]                         wrdata;
    logic [bootloader_pkg::ADDR_W-1:0]   wraddr;
    logic                                bl_stall;
    logic                                done;
    logic                                error;

    modport master (
        input  start, rx_data, rx_valid,
        output rx_ready, wr_strobe, wrdata, wraddr, bl_stall, done, error
    );

    modport slave (
        output start, rx_data, rx_valid,
        input  rx_ready, wr_strobe, wrdata, wraddr, bl_stall, done, error
    );

endinterface

// File: rtl/imem_bootloader_timeout.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear.
// expired is high on the TIMEOUT-th consecutive enabled cycle without a clear.
module bl_timeout #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    assign expired = enable && (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/imem_bootloader.sv
// Loads a MAGIC/LEN/data/CHK byte image into imem, one word write per 4 bytes.
// Write lands the cycle after a word's 4th byte; stalls the CPU while loading or failed.
module imem_bootloader
    import bootloader_pkg::*;
#(
    parameter logic [7:0] MAGIC   = MAGIC_DEFAULT,
    parameter int         TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    imem_bootloader_if.master bus
);

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          byte_cnt;
    logic [23:0]         word_buf;
    logic [ADDR_W-1:0]   len;
    logic [ADDR_W-1:0]   word_idx;
    logic [7:0]          chk;
    logic [31:0]         wrdata_q;
    logic [3:0]          wr_strobe_q;
    logic                rx_ready_q;
    logic                bl_stall_q;
    logic                done_q;
    logic                error_q;

    logic                xfer;
    logic                start_ok;
    logic                expired;
    logic                to_clear;
    logic                to_enable;
    logic [ADDR_W-1:0]   len_in;

    assign xfer      = bus.rx_valid && rx_ready_q;
    assign start_ok  = bus.start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
    assign to_enable = is_rx_state(state);
    assign to_clear  = xfer || start_ok || !to_enable;
    assign len_in    = {bus.rx_data[5:0], len[7:0]};

    bl_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (to_clear),
        .enable  (to_enable),
        .expired (expired)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: if (bus.start) state_nxt = ST_MAGIC;
            ST_MAGIC:  if (xfer) state_nxt = (bus.rx_data == MAGIC) ? ST_LEN_LO : ST_ERROR;
            ST_LEN_LO: if (xfer) state_nxt = ST_LEN_HI;
            ST_LEN_HI: begin
                if (xfer) begin
                    if (bus.rx_data[7:6] != 2'b00) state_nxt = ST_ERROR;
                    else if (len_in == '0)         state_nxt = ST_CHECK;
                    else                           state_nxt = ST_DATA;
                end
            end
            ST_DATA:   if (xfer && (byte_cnt == 2'd3)) state_nxt = ST_WRITE;
            ST_WRITE:  state_nxt = (word_idx == len - 1'b1) ? ST_CHECK : ST_DATA;
            ST_CHECK:  if (xfer) state_nxt = (bus.rx_data == chk) ? ST_DONE : ST_ERROR;
            default:   state_nxt = ST_IDLE;
        endcase
        // A byte accepted on the expiry cycle still counts.
        if (to_enable && !xfer && expired) state_nxt = ST_ERROR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            byte_cnt    <= '0;
            word_buf    <= '0;
            len         <= '0;
            word_idx    <= '0;
            chk         <= '0;
            wrdata_q    <= '0;
            wr_strobe_q <= '0;
            rx_ready_q  <= 1'b0;
            bl_stall_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            rx_ready_q  <= is_rx_state(state_nxt);
            bl_stall_q  <= !((state_nxt == ST_IDLE) || (state_nxt == ST_DONE));
            done_q      <= (state_nxt == ST_DONE);
            error_q     <= (state_nxt == ST_ERROR);
            wr_strobe_q <= (state_nxt == ST_WRITE) ? 4'hF : 4'h0;

            if (start_ok) begin
                word_idx <= '0;
                chk      <= '0;
                byte_cnt <= '0;
            end

            if (xfer) begin
                case (state)
                    ST_LEN_LO: begin
                        len[7:0] <= bus.rx_data;
                        chk      <= chk ^ bus.rx_data;
                    end
                    ST_LEN_HI: begin
                        len[13:8] <= bus.rx_data[5:0];
                        chk       <= chk ^ bus.rx_data;
                    end
                    ST_DATA: begin
                        chk      <= chk ^ bus.rx_data;
                        byte_cnt <= byte_cnt + 1'b1;
                        case (byte_cnt)
                            2'd0:    word_buf[7:0]   <= bus.rx_data;
                            2'd1:    word_buf[15:8]  <= bus.rx_data;
                            2'd2:    word_buf[23:16] <= bus.rx_data;
                            default: wrdata_q        <= {bus.rx_data, word_buf};
                        endcase
                    end
                    default: ;
                endcase
            end

            if ((state == ST_WRITE) && (state_nxt == ST_DATA)) begin
                word_idx <= word_idx + 1'b1;
            end
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wrdata    = wrdata_q;
    assign bus.wraddr    = word_idx;
    assign bus.bl_stall  = bl_stall_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_imem_bootloader.sv
// Directed bench for imem_bootloader with TIMEOUT=16 and hand-computed images.
module tb_imem_bootloader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   last_acc = 0;
    int   err_cyc  = 0;

    logic [7:0]  seq[$];
    int          acc_q[$];
    logic [31:0] wr_dat_q[$];
    int          wr_adr_q[$];
    int          wr_cyc_q[$];
    logic [3:0]  wr_stb_q[$];
    logic        wr_rdy_q[$];

    imem_bootloader_if bus ();

    imem_bootloader #(.MAGIC(8'hA5), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.wr_strobe != 4'h0) begin
            wr_dat_q.push_back(bus.wrdata);
            wr_adr_q.push_back(int'(bus.wraddr));
            wr_cyc_q.push_back(cyc);
            wr_stb_q.push_back(bus.wr_strobe);
            wr_rdy_q.push_back(bus.rx_ready);
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        acc_q.delete();
        wr_dat_q.delete();
        wr_adr_q.delete();
        wr_cyc_q.delete();
        wr_stb_q.delete();
        wr_rdy_q.delete();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk_eq("send_byte_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        last_acc = cyc;
        acc_q.push_back(cyc);
    endtask

    task automatic send_seq(input int gap);
        foreach (seq[i]) begin
            send_byte(seq[i]);
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_end();
        int n = 0;
        @(negedge clk);
        while (!(bus.done || bus.error) && n < 200) begin
            @(negedge clk);
            n++;
        end
        err_cyc = cyc;
        if (n >= 200) chk_eq("wait_end_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_happy_writes(input string tag);
        chk_eq({tag, "_nwr"}, wr_dat_q.size(), 2);
        if (wr_dat_q.size() == 2) begin
            chk_eq({tag, "_dat0"}, wr_dat_q[0], 32'h1234_5678);
            chk_eq({tag, "_adr0"}, wr_adr_q[0], 0);
            chk_eq({tag, "_dat1"}, wr_dat_q[1], 32'hDEAD_BEEF);
            chk_eq({tag, "_adr1"}, wr_adr_q[1], 1);
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_rx_ready", bus.rx_ready, 0);
        chk_eq("rst_wr_strobe", bus.wr_strobe, 0);
        chk_eq("rst_wrdata", bus.wrdata, 0);
        chk_eq("rst_wraddr", bus.wraddr, 0);
        chk_eq("rst_bl_stall", bus.bl_stall, 0);
        chk_eq("rst_done", bus.done, 0);
        chk_eq("rst_error", bus.error, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // happy path, CHK = 02^00^78^56^34^12^EF^BE^AD^DE = 28
        clear_log();
        pulse_start();
        chk_eq("hp_stall_loading", bus.bl_stall, 1);
        chk_eq("hp_ready_magic", bus.rx_ready, 1);
        seq = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
        send_seq(0);
        wait_end();
        chk_eq("hp_done", bus.done, 1);
        chk_eq("hp_error", bus.error, 0);
        chk_eq("hp_stall", bus.bl_stall, 0);
        check_happy_writes("hp");
        if (wr_cyc_q.size() == 2) begin
            chk_eq("hp_lat0", wr_cyc_q[0], acc_q[6]);
            chk_eq("hp_lat1", wr_cyc_q[1], acc_q[10]);
            chk_eq("hp_strobe", wr_stb_q[0], 4'hF);
            chk_eq("hp_ready_in_write", wr_rdy_q[0], 0);
        end

        // bad magic
        clear_log();
        pulse_start();
        chk_eq("bm_done_cleared", bus.done, 0);
        seq = {8'h5A};
        send_seq(0);
        wait_end();
        chk_eq("bm_error", bus.error, 1);
        chk_eq("bm_stall", bus.bl_stall, 1);
        chk_eq("bm_done", bus.done, 0);
        chk_eq("bm_nwr", wr_dat_q.size(), 0);

        // checksum fault
        clear_log();
        pulse_start();
        chk_eq("cf_error_cleared", bus.error, 0);
        chk_eq("cf_ready", bus.rx_ready, 1);
        seq = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h29};
        send_seq(0);
        wait_end();
        check_happy_writes("cf");
        chk_eq("cf_error", bus.error, 1);
        chk_eq("cf_done", bus.done, 0);
        chk_eq("cf_stall", bus.bl_stall, 1);

        // zero length
        clear_log();
        pulse_start();
        seq = {8'hA5, 8'h00, 8'h00, 8'h00};
        send_seq(0);
        wait_end();
        chk_eq("zl_done", bus.done, 1);
        chk_eq("zl_error", bus.error, 0);
        chk_eq("zl_nwr", wr_dat_q.size(), 0);
        chk_eq("zl_wraddr", bus.wraddr, 0);

        // LEN_HI out of range
        pulse_start();
        seq = {8'hA5, 8'h00, 8'h40};
        send_seq(0);
        wait_end();
        chk_eq("lh_error", bus.error, 1);
        chk_eq("lh_done", bus.done, 0);

        // valid toggling every other cycle
        clear_log();
        pulse_start();
        seq = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
        send_seq(1);
        wait_end();
        chk_eq("bp_done", bus.done, 1);
        check_happy_writes("bp");

        // stall after 3 data bytes: error exactly 16 cycles later
        clear_log();
        pulse_start();
        seq = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34};
        send_seq(0);
        wait_end();
        chk_eq("to_error", bus.error, 1);
        chk_eq("to_delay", err_cyc - last_acc, 16);
        chk_eq("to_nwr", wr_dat_q.size(), 0);

        // reset mid-DATA, after a previous word left wrdata non-zero
        clear_log();
        pulse_start();
        seq = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56};
        send_seq(0);
        chk_eq("mr_stall_before", bus.bl_stall, 1);
        #2 rst = 1'b1;
        #1;
        chk_eq("mr_stall", bus.bl_stall, 0);
        chk_eq("mr_ready", bus.rx_ready, 0);
        chk_eq("mr_wrdata", bus.wrdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // full load with a stray start mid-image
        clear_log();
        pulse_start();
        seq = {8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
        fork
            send_seq(0);
            begin
                repeat (7) @(posedge clk);
                #1;
                pulse_start();
            end
        join
        wait_end();
        chk_eq("ms_done", bus.done, 1);
        chk_eq("ms_error", bus.error, 0);
        chk_eq("ms_stall", bus.bl_stall, 0);
        check_happy_writes("ms");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
